// File: rtl/s9_alu_pkg.sv
// Shared types and constants for the sequential ALU front-end.
// FSM states, opcodes, flag bit positions and the opcode check.
package s9_alu_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SHOW    = 3'd3,
        ERROR   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } op_t;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_P = 0;

    function automatic logic op_is_valid(input logic [2:0] code);
        return (code <= 3'd4);
    endfunction

endpackage

// File: rtl/s9_alu_core.sv
// Combinational ALU datapath: result and {N,Z,C,V,P} for one operation.
// The caller registers both outputs.
module s9_alu_core
    import s9_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       flags_o
);

    logic [WIDTH:0] ext_s;
    logic           carry_s;
    logic           ovf_s;

    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Operation select in WIDTH+1 bits so the top bit carries C (or borrow for SUB).
    always_comb begin
        ext_s   = {(WIDTH+1){1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op_i)
            OP_ADD: begin
                ext_s   = {1'b0, a_i} + {1'b0, b_i};
                carry_s = ext_s[WIDTH];
                ovf_s   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (ext_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                ext_s   = {1'b0, a_i} - {1'b0, b_i};
                carry_s = ext_s[WIDTH];
                ovf_s   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (ext_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  ext_s = {1'b0, a_i & b_i};
            OP_OR:   ext_s = {1'b0, a_i | b_i};
            OP_XOR:  ext_s = {1'b0, a_i ^ b_i};
            default: ext_s = {(WIDTH+1){1'b0}};
        endcase
    end

    // Flag assembly from the truncated result.
    always_comb begin
        result_o         = ext_s[WIDTH-1:0];
        flags_o          = 5'b00000;
        flags_o[FLAG_N]  = ext_s[WIDTH-1];
        flags_o[FLAG_Z]  = (ext_s[WIDTH-1:0] == {WIDTH{1'b0}});
        flags_o[FLAG_C]  = carry_s;
        flags_o[FLAG_V]  = ovf_s;
        flags_o[FLAG_P]  = parity_f(ext_s[WIDTH-1:0]);
    end

endmodule

// File: rtl/s9_alu_seq_ctrl.sv
// Sequential ALU front-end: A, B and opcode entered on one bus, one Enter press each.
// Result and flags are held for the display; optional chaining reuses the result as A.
module s9_alu_seq_ctrl
    import s9_alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Enter,
    input  logic             Chain,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] ToDisplay,
    output logic [4:0]       Flags,
    output logic [2:0]       Status
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic [4:0]       flags_q, flags_d;
    logic             enter_q;
    logic             arm_q;
    logic             go_s;
    logic [WIDTH-1:0] core_result_s;
    logic [4:0]       core_flags_s;

    // arm_q blocks a press that was already held when reset released.
    assign go_s = Enter & ~enter_q & arm_q;

    s9_alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (DataIn[2:0]),
        .result_o (core_result_s),
        .flags_o  (core_flags_s)
    );

    // Next-state, operand capture and display/flag selection.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        disp_d   = disp_q;
        flags_d  = flags_q;
        case (state_q)
            WAIT_A: begin
                disp_d = DataIn;
                if (go_s) begin
                    a_d     = DataIn;
                    state_d = WAIT_B;
                end else begin
                    state_d = WAIT_A;
                end
            end
            WAIT_B: begin
                disp_d = DataIn;
                if (go_s) begin
                    b_d     = DataIn;
                    state_d = WAIT_OP;
                end else begin
                    state_d = WAIT_B;
                end
            end
            WAIT_OP: begin
                disp_d = {{(WIDTH-3){1'b0}}, DataIn[2:0]};
                if (go_s && op_is_valid(DataIn[2:0])) begin
                    result_d = core_result_s;
                    disp_d   = core_result_s;
                    flags_d  = core_flags_s;
                    state_d  = SHOW;
                end else if (go_s) begin
                    disp_d  = {WIDTH{1'b1}};
                    flags_d = 5'b00000;
                    state_d = ERROR;
                end else begin
                    state_d = WAIT_OP;
                end
            end
            SHOW: begin
                disp_d = result_q;
                if (go_s && Chain && CHAIN_EN) begin
                    a_d     = result_q;
                    state_d = WAIT_B;
                end else if (go_s) begin
                    flags_d = 5'b00000;
                    state_d = WAIT_A;
                end else begin
                    state_d = SHOW;
                end
            end
            ERROR: begin
                disp_d  = {WIDTH{1'b1}};
                flags_d = 5'b00000;
                if (go_s) begin
                    state_d = WAIT_A;
                end else begin
                    state_d = ERROR;
                end
            end
            default: begin
                disp_d  = {WIDTH{1'b0}};
                flags_d = 5'b00000;
                state_d = WAIT_A;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_A;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            disp_q   <= {WIDTH{1'b0}};
            flags_q  <= 5'b00000;
            enter_q  <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            disp_q   <= disp_d;
            flags_q  <= flags_d;
            enter_q  <= Enter;
            arm_q    <= arm_q | ~Enter;
        end
    end

    assign ToDisplay = disp_q;
    assign Flags     = flags_q;
    assign Status    = state_q;

endmodule
